// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between a fetch and a data requester
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_read,
    input  logic [23:0] f_addr,
    input  logic [1:0]  f_count,
    output logic [31:0] f_data,
    output logic        f_done,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [23:0] d_addr,
    input  logic [1:0]  d_count,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        err,
    output logic        busy,
    output logic [23:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_dataIn,
    output logic [1:0]  m_byteCount,
    input  logic [31:0] m_dataOut,
    input  logic        m_dataOutReady,
    input  logic        m_dataInReady
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic last_data, owner_data, is_write, rdy_q;
    logic [31:0] rdata_q;
    logic pick_data, pick_write, grant, hit, take, finish, wait_more, abort;

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    // next state: one BUSY transaction, always followed by a single RECOVER cycle
    always_comb begin
        state_nxt = state == IDLE ? (grant ? BUSY : IDLE) :
                    state == BUSY ? (finish || abort ? RECOVER : BUSY) : IDLE;
    end

    // control decode: data wins only if fetch is idle or fetch had the last grant
    always_comb begin
        pick_data  = (d_read | d_write) & (~f_read | ~last_data);
        pick_write = pick_data & d_write & ~d_read;
        grant      = (state == IDLE) & (f_read | d_read | d_write);
        hit        = is_write ? m_dataInReady : m_dataOutReady;
        take       = (state == BUSY) & ~rdy_q & hit;
        finish     = (state == BUSY) & rdy_q;
        wait_more  = (state == BUSY) & ~rdy_q & ~hit;
        abort      = wait_more & (cnt == CW'(TIMEOUT - 1));
    end

    // capture the expected ready and its data; readies outside BUSY never register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rdy_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rdy_q <= take;
            if (take) rdata_q <= m_dataOut;
        end

    // timeout counter: counts BUSY cycles that saw no expected ready
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (grant) cnt <= '0;
        else if (wait_more) cnt <= cnt + 1'b1;

    // latch the winner's request and drive the memory strobes
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            m_address   <= '0;
            m_byteCount <= '0;
            m_dataIn    <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            owner_data  <= 1'b0;
            is_write    <= 1'b0;
            last_data   <= 1'b1;
        end else if (grant) begin
            m_address   <= pick_data ? d_addr : f_addr;
            m_byteCount <= pick_data ? d_count : f_count;
            if (pick_data) m_dataIn <= d_wdata;
            m_read      <= ~pick_write;
            m_write     <= pick_write;
            owner_data  <= pick_data;
            is_write    <= pick_write;
            last_data   <= pick_data;
        end else if (finish || abort) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
        end

    // completion pulses, error flag, busy and returned read data
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            f_done  <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            f_data  <= '0;
            d_rdata <= '0;
        end else begin
            f_done <= (finish | abort) & ~owner_data;
            d_done <= (finish | abort) & owner_data;
            err    <= abort;
            busy   <= state_nxt != IDLE;
            if ((finish & ~is_write) | abort) begin
                if (owner_data) d_rdata <= abort ? 32'd0 : rdata_q;
                else f_data <= abort ? 32'd0 : rdata_q;
            end
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a requester/memory model
module tb_mem_arbiter;
    localparam int TIMEOUT = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic f_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [23:0] f_addr = '0, d_addr = '0;
    logic [1:0] f_count = '0, d_count = '0;
    logic [31:0] d_wdata = '0, m_dataOut = '0;
    logic m_dataOutReady = 1'b0, m_dataInReady = 1'b0;
    logic [31:0] f_data, d_rdata, m_dataIn;
    logic f_done, d_done, err, busy, m_read, m_write;
    logic [23:0] m_address;
    logic [1:0] m_byteCount;

    int pass_cnt = 0;
    int chk_cnt = 0;

    // requester model: pending level and the fields each requester holds
    bit fp = 0, dp = 0, dr = 0, dwr = 0;
    logic [23:0] fa = '0, da = '0;
    logic [1:0] fc = '0, dc = '0;
    logic [31:0] dw = '0;
    bit last_was_data = 1;
    logic [31:0] exp_f = '0, exp_d = '0;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .f_read(f_read), .f_addr(f_addr), .f_count(f_count), .f_data(f_data), .f_done(f_done),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_count(d_count),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .err(err), .busy(busy),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_dataIn(m_dataIn),
        .m_byteCount(m_byteCount), .m_dataOut(m_dataOut),
        .m_dataOutReady(m_dataOutReady), .m_dataInReady(m_dataInReady)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive_reqs();
        f_read  = fp;
        f_addr  = fa;
        f_count = fc;
        d_read  = dp & dr;
        d_write = dp & dwr;
        d_addr  = da;
        d_count = dc;
        d_wdata = dw;
    endtask

    // one arbitration round starting in an IDLE cycle; k = BUSY cycle the memory answers in
    task automatic run_txn(input bit add_f, input int add_d, input int k, input int stray,
                           input bit idle_stray, input logic [31:0] rdv);
        bit wd, wr, exp_err;
        int done_cyc;
        logic [23:0] exp_addr;
        logic [1:0] exp_cnt;
        check("idle_busy", busy, 0);
        check("idle_mem", {m_read, m_write}, 0);
        check("idle_done", {f_done, d_done, err}, 0);
        if (add_f && !fp) begin
            fp = 1; fa = $urandom; fc = $urandom;
        end
        if (add_d != 0 && !dp) begin
            dp = 1; dr = add_d != 2; dwr = add_d >= 2; da = $urandom; dc = $urandom; dw = $urandom;
        end
        if (!fp && !dp) begin
            fp = 1; fa = $urandom; fc = $urandom;
        end
        drive_reqs();
        m_dataInReady  = idle_stray;
        m_dataOutReady = idle_stray;
        wd = dp && (!fp || !last_was_data);
        last_was_data = wd;
        wr = wd && dwr && !dr;
        exp_addr = wd ? da : fa;
        exp_cnt  = wd ? dc : fc;
        exp_err  = k > TIMEOUT;
        done_cyc = exp_err ? TIMEOUT + 1 : k + 2;
        @(posedge clk); #1;
        m_dataInReady = 0; m_dataOutReady = 0;
        check("grant_addr", m_address, exp_addr);
        check("grant_count", m_byteCount, exp_cnt);
        check("grant_busy", busy, 1);
        if (wr) check("grant_wdata", m_dataIn, dw);
        for (int c = 1; c < done_cyc; c++) begin
            check("hold_mem", {m_read, m_write}, {!wr, wr});
            check("hold_addr", m_address, exp_addr);
            check("no_done", {f_done, d_done}, 0);
            m_dataOut = $urandom;
            if (c == k) begin
                if (wr) m_dataInReady = 1;
                else begin
                    m_dataOutReady = 1; m_dataOut = rdv;
                end
            end
            if (c == stray && c != k) begin
                if (wr) m_dataOutReady = 1;
                else m_dataInReady = 1;
            end
            @(posedge clk); #1;
            m_dataInReady = 0; m_dataOutReady = 0; m_dataOut = $urandom;
        end
        if (!wr || exp_err) begin
            if (wd) exp_d = exp_err ? 32'd0 : rdv;
            else exp_f = exp_err ? 32'd0 : rdv;
        end
        check("f_done", f_done, !wd);
        check("d_done", d_done, wd);
        check("err", err, exp_err);
        check("f_data", f_data, exp_f);
        check("d_rdata", d_rdata, exp_d);
        check("recover_mem", {m_read, m_write}, 0);
        check("recover_busy", busy, 1);
        if (wd) dp = 0;
        else fp = 0;
        drive_reqs();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] mem_bytes [4];
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem", {m_read, m_write, busy, f_done, d_done, err}, 0);
        check("rst_addr", m_address, 0);
        check("rst_wdata", m_dataIn, 0);
        check("rst_count", m_byteCount, 0);
        check("rst_fdata", f_data, 0);
        check("rst_drdata", d_rdata, 0);
        rst = 0;
        @(posedge clk); #1;

        // contention from reset: both reads held, fetch wins first, then alternate
        for (int i = 0; i < 4; i++) run_txn(1, 1, $urandom_range(1, 6), 0, 0, $urandom);

        // fetch read of bytes 05 BA AD 05, little-endian assembly
        mem_bytes[0] = 8'h05; mem_bytes[1] = 8'hBA; mem_bytes[2] = 8'hAD; mem_bytes[3] = 8'h05;
        fp = 1; fa = 24'h000100; fc = 2'd3;
        run_txn(0, 0, 2, 0, 0, {mem_bytes[3], mem_bytes[2], mem_bytes[1], mem_bytes[0]});
        check("f_data_le", f_data, 32'h05ADBA05);

        // data write with a stray read-ready and a stray IDLE ready
        dp = 1; dr = 0; dwr = 1; da = 24'h000010; dc = 2'd1; dw = 32'h0000BEEF;
        run_txn(0, 0, 3, 1, 1, 32'h0);

        // data read that never gets an answer
        dp = 1; dr = 1; dwr = 0; da = 24'h000200; dc = 2'd3; dw = $urandom;
        run_txn(0, 0, 99, 2, 0, 32'h0);

        // answer in the very cycle the timeout would fire, and one cycle too late
        run_txn(1, 0, TIMEOUT, 0, 0, 32'hCAFEF00D);
        run_txn(0, 3, TIMEOUT + 1, 0, 0, 32'h0);

        // reset while a fetch is in BUSY
        fp = 1; fa = 24'h0000AA; fc = 2'd0;
        drive_reqs();
        @(posedge clk); #1;
        check("pre_rst_read", m_read, 1);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("rst_async_read", m_read, 0);
        check("rst_async_busy", busy, 0);
        @(posedge clk); #1;
        fp = 0; dp = 0; last_was_data = 1; exp_f = 0; exp_d = 0;
        drive_reqs();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rst_no_done", {f_done, d_done, err, m_read, m_write}, 0);
        end
        fp = 1; fa = 24'h123456; fc = 2'd2;
        run_txn(0, 0, 4, 0, 0, 32'h12345678);

        // randomized rounds
        for (int i = 0; i < 150; i++)
            run_txn($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(1, TIMEOUT + 4),
                    $urandom_range(0, 20), $urandom_range(0, 1), $urandom);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
